// File: rtl/tx_sched_pkg.sv
// Shared types and default constants for the transmit ordered-set scheduler.
// Lengths are in transmit cycles; the slot counter is sized from the longest slot.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_DATA = 2'd1,
    TX_SKP  = 2'd2,
    TX_OS   = 2'd3
  } tx_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_SKP,
    ST_OS
  } state_e;

  localparam int SKP_LEN_GEN1_DEF = 4;
  localparam int SKP_LEN_GEN3_DEF = 16;
  localparam int OS_LEN_DEF       = 16;
  localparam int MAX_PEND_DEF     = 2;
  localparam int PEND_W_DEF       = 2;

  function automatic int len_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic tx_sel_e sel_of(input state_e s);
    case (s)
      ST_DATA: return TX_DATA;
      ST_SKP:  return TX_SKP;
      ST_OS:   return TX_OS;
      default: return TX_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/skp_pend_tracker.sv
// SKP request capture, skp_done handshake and saturating queue of pending SKPs.
// A capture made in the same cycle the scheduler starts an SKP is consumed immediately.
module skp_pend_tracker
  import tx_sched_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int PEND_W   = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_skp_enable,
  input  logic              i_skp_rst,
  input  logic              i_dec,
  output logic              o_skp_done,
  output logic              o_capture,
  output logic [PEND_W-1:0] o_pend
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  logic              r_skp_done;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_next;
  logic              w_capture;

  assign w_capture  = i_skp_enable & ~r_skp_done;
  assign o_capture  = w_capture;
  assign o_skp_done = r_skp_done;
  assign o_pend     = r_pend;

  // A queue flush keeps only a capture that was not already consumed by a slot start.
  always_comb begin
    w_pend_next = r_pend;
    if (i_skp_rst) begin
      w_pend_next = (w_capture & ~(i_dec & (r_pend == '0))) ? PEND_W'(1) : '0;
    end else if (w_capture & ~i_dec) begin
      if (r_pend != PEND_MAX) w_pend_next = r_pend + PEND_W'(1);
    end else if (~w_capture & i_dec) begin
      w_pend_next = r_pend - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skp_done <= 1'b0;
      r_pend     <= '0;
    end else begin
      r_skp_done <= w_capture | (r_skp_done & i_skp_enable);
      r_pend     <= w_pend_next;
    end
  end

endmodule

// File: rtl/tx_os_scheduler.sv
// Lane TX scheduler arbitrating data packets, LTSSM ordered sets and SKPs at packet boundaries.
// Define TX_OS_SCHED_STATS_EN to add the skp_sent_cnt / skp_drop_cnt statistics outputs.
module tx_os_scheduler
  import tx_sched_pkg::*;
#(
  parameter int SKP_LEN_GEN1 = SKP_LEN_GEN1_DEF,
  parameter int SKP_LEN_GEN3 = SKP_LEN_GEN3_DEF,
  parameter int OS_LEN       = OS_LEN_DEF,
  parameter int MAX_PEND     = MAX_PEND_DEF,
  parameter int PEND_W       = PEND_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gen,
  input  logic       skp_enable,
  output logic       skp_done,
  input  logic       skp_rst,
  output logic       back_pressure,
  input  logic       os_req,
  output logic       os_grant,
  input  logic       dl_valid,
  input  logic       dl_eop,
  output logic       dl_ready,
  input  logic       phy_ready,
  output logic       skp_start,
  output logic       os_start,
  output logic [1:0] tx_sel
`ifdef TX_OS_SCHED_STATS_EN
  ,
  output logic [15:0] skp_sent_cnt,
  output logic [15:0] skp_drop_cnt
`endif
);

  localparam int CNT_W = len_width(SKP_LEN_GEN1, SKP_LEN_GEN3, OS_LEN);

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_in_pkt, w_in_pkt_next;
  logic              r_skp_start, r_os_start;
  logic              w_enter_skp, w_enter_os, w_arb;
  logic              w_accept, w_skp_avail, w_capture;
  logic [PEND_W-1:0] w_pend;

  skp_pend_tracker #(
    .MAX_PEND (MAX_PEND),
    .PEND_W   (PEND_W)
  ) u_pend (
    .clk          (clk),
    .rst          (rst),
    .i_skp_enable (skp_enable),
    .i_skp_rst    (skp_rst),
    .i_dec        (w_enter_skp),
    .o_skp_done   (skp_done),
    .o_capture    (w_capture),
    .o_pend       (w_pend)
  );

  assign back_pressure = ~phy_ready;
  assign dl_ready      = phy_ready & (r_state == ST_DATA) & (r_in_pkt | ((w_pend == '0) & ~os_req));
  assign w_accept      = dl_valid & dl_ready;
  assign w_skp_avail   = (w_pend != '0) | w_capture;

  // Arbitration also runs on the eop-acceptance cycle, so the next slot starts right after it.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_enter_skp   = 1'b0;
    w_enter_os    = 1'b0;
    w_in_pkt_next = r_in_pkt;
    if (w_accept) w_in_pkt_next = ~dl_eop;
    case (r_state)
      ST_IDLE: w_arb = phy_ready;
      ST_DATA: w_arb = phy_ready & ~w_in_pkt_next;
      default: w_arb = phy_ready & (r_cnt == CNT_W'(1));
    endcase
    if (w_arb) begin
      if (w_skp_avail) begin
        w_state_next = ST_SKP;
        w_cnt_next   = gen ? CNT_W'(SKP_LEN_GEN3) : CNT_W'(SKP_LEN_GEN1);
        w_enter_skp  = 1'b1;
      end else if (os_req) begin
        w_state_next = ST_OS;
        w_cnt_next   = CNT_W'(OS_LEN);
        w_enter_os   = 1'b1;
      end else if (dl_valid) begin
        w_state_next = ST_DATA;
      end else begin
        w_state_next = ST_IDLE;
      end
    end else if (phy_ready && (r_state == ST_SKP || r_state == ST_OS)) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_pkt    <= 1'b0;
      r_skp_start <= 1'b0;
      r_os_start  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_in_pkt    <= w_in_pkt_next;
      r_skp_start <= w_enter_skp;
      r_os_start  <= w_enter_os;
    end
  end

  assign skp_start = r_skp_start;
  assign os_start  = r_os_start;
  assign os_grant  = r_os_start;
  assign tx_sel    = sel_of(r_state);

`ifdef TX_OS_SCHED_STATS_EN
  logic [15:0] r_sent_cnt, r_drop_cnt;
  logic        w_drop;

  // A capture is only lost when the queue is full and nothing leaves it this cycle.
  assign w_drop = w_capture & ~w_enter_skp & ~skp_rst & (w_pend == PEND_W'(MAX_PEND));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_sent_cnt <= r_sent_cnt + 16'(w_enter_skp);
      r_drop_cnt <= r_drop_cnt + 16'(w_drop);
    end
  end

  assign skp_sent_cnt = r_sent_cnt;
  assign skp_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tx_os_scheduler.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a behavioural model,
// a negedge monitor pops and compares them against the scheduler outputs.
module tb_tx_os_scheduler;

  localparam int LEN1  = 4;
  localparam int LEN3  = 16;
  localparam int OSL   = 16;
  localparam int MAXP  = 2;

  logic clk = 1'b0;
  logic rst, gen, skp_enable, skp_rst, os_req, dl_valid, dl_eop, phy_ready;
  logic skp_done, back_pressure, os_grant, dl_ready, skp_start, os_start;
  logic [1:0] tx_sel;
`ifdef TX_OS_SCHED_STATS_EN
  logic [15:0] skp_sent_cnt, skp_drop_cnt;
`endif

  tx_os_scheduler #(
    .SKP_LEN_GEN1 (LEN1),
    .SKP_LEN_GEN3 (LEN3),
    .OS_LEN       (OSL),
    .MAX_PEND     (MAXP),
    .PEND_W       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gen           (gen),
    .skp_enable    (skp_enable),
    .skp_done      (skp_done),
    .skp_rst       (skp_rst),
    .back_pressure (back_pressure),
    .os_req        (os_req),
    .os_grant      (os_grant),
    .dl_valid      (dl_valid),
    .dl_eop        (dl_eop),
    .dl_ready      (dl_ready),
    .phy_ready     (phy_ready),
    .skp_start     (skp_start),
    .os_start      (os_start),
    .tx_sel        (tx_sel)
`ifdef TX_OS_SCHED_STATS_EN
    ,
    .skp_sent_cnt  (skp_sent_cnt),
    .skp_drop_cnt  (skp_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] tx_sel;
    logic       skp_done, skp_start, os_start, dl_ready, back_pressure;
    int         sent, drop;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: activity (0 idle, 1 data, 2 skp, 3 os), remaining slot symbols,
  // number of queued SKPs, packet-open flag and the counter handshake.
  int m_act, m_left, m_pend, m_sent, m_drop;
  bit m_done, m_open, m_skp_start, m_os_start, m_acc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return phy_ready && m_act == 1 && (m_open || (m_pend == 0 && !os_req));
  endfunction

  task automatic model_reset();
    m_act = 0; m_left = 0; m_pend = 0; m_sent = 0; m_drop = 0;
    m_done = 0; m_open = 0; m_skp_start = 0; m_os_start = 0; m_acc = 0;
  endtask

  task automatic model_step();
    bit cap, acc, open_after, free;
    int p;
    cap = skp_enable && !m_done;
    acc = dl_valid && model_ready();
    m_acc = acc;
    if (rst) begin
      model_reset();
      return;
    end
    open_after = acc ? !dl_eop : m_open;
    free = phy_ready && (m_act == 0 || (m_act == 1 && !open_after) || (m_act >= 2 && m_left == 1));
    p = m_pend + int'(cap);
    m_skp_start = 0;
    m_os_start  = 0;
    if (free) begin
      if (p > 0) begin
        m_act = 2; m_left = gen ? LEN3 : LEN1; p--; m_skp_start = 1; m_sent++;
      end else if (os_req) begin
        m_act = 3; m_left = OSL; m_os_start = 1;
      end else begin
        m_act = dl_valid ? 1 : 0;
      end
    end else if (phy_ready && m_act >= 2) begin
      m_left--;
    end
    if (skp_rst) p = (cap && !(m_skp_start && m_pend == 0)) ? 1 : 0;
    else if (p > MAXP) begin
      p = MAXP; m_drop++;
    end
    m_pend = p;
    m_done = cap || (m_done && skp_enable);
    m_open = open_after;
  endtask

  // Inputs are set between posedge+1 and the next posedge; the requesters drop
  // their levels once they see their acknowledge.
  task automatic step_cycle();
    exp_t e;
    if (m_os_start) os_req = 1'b0;
    if (m_done) skp_enable = 1'b0;
    e.tx_sel = 2'(m_act); e.skp_done = m_done; e.skp_start = m_skp_start;
    e.os_start = m_os_start; e.dl_ready = model_ready(); e.back_pressure = !phy_ready;
    e.sent = m_sent; e.drop = m_drop;
    sb.push_back(e);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      dl_valid = 0; dl_eop = 0; skp_rst = 0; rst = 0; phy_ready = 1;
      step_cycle();
    end
  endtask

  task automatic send_pkt(input int n, input int ea, input int eb, input int ec,
                          input int srst_beat, input int os_beat);
    int beat = 0;
    int guard = 0;
    while (beat < n && guard < 400) begin
      rst = 0; phy_ready = 1; dl_valid = 1; dl_eop = (beat == n - 1);
      if (beat == ea || beat == eb || beat == ec) skp_enable = 1;
      if (beat == os_beat) os_req = 1;
      skp_rst = (beat == srst_beat);
      step_cycle();
      if (m_acc) beat++;
      guard++;
    end
    dl_valid = 0; dl_eop = 0; skp_rst = 0;
    check("pkt_complete", 16'(beat), 16'(n));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("tx_sel", 16'(tx_sel), 16'(e.tx_sel));
        check("skp_done", 16'(skp_done), 16'(e.skp_done));
        check("skp_start", 16'(skp_start), 16'(e.skp_start));
        check("os_start", 16'(os_start), 16'(e.os_start));
        check("os_grant", 16'(os_grant), 16'(e.os_start));
        check("dl_ready", 16'(dl_ready), 16'(e.dl_ready));
        check("back_pressure", 16'(back_pressure), 16'(e.back_pressure));
`ifdef TX_OS_SCHED_STATS_EN
        check("skp_sent_cnt", skp_sent_cnt, 16'(e.sent));
        check("skp_drop_cnt", skp_drop_cnt, 16'(e.drop));
`endif
      end
    end
  end

  initial begin
    rst = 1; gen = 1; skp_enable = 0; skp_rst = 0; os_req = 0;
    dl_valid = 0; dl_eop = 0; phy_ready = 1;
    model_reset();
    @(posedge clk);
    #1;
    step_cycle();
    rst = 0;
    quiet(3);

    // Single SKP on an idle link with the high-gen length.
    gen = 1; skp_enable = 1;
    quiet(22);

    // SKP requested mid-packet waits for the eop; low-gen slot then data resumes.
    gen = 0;
    send_pkt(10, 3, -1, -1, -1, -1);
    send_pkt(3, -1, -1, -1, -1, -1);
    quiet(4);

    // Three captures in one long packet saturate the queue.
    send_pkt(40, 5, 15, 25, -1, -1);
    send_pkt(2, -1, -1, -1, -1, -1);
    quiet(4);

    // Pending SKP and ordered-set request at the same boundary.
    send_pkt(6, 2, -1, -1, -1, 2);
    send_pkt(3, -1, -1, -1, -1, -1);
    quiet(25);

    // PHY stall in the middle of a high-gen SKP.
    gen = 1; skp_enable = 1;
    quiet(5);
    repeat (5) begin
      phy_ready = 0;
      step_cycle();
    end
    quiet(20);

    // Queue flush with two SKPs pending during a packet.
    gen = 0;
    send_pkt(20, 3, 8, -1, 12, -1);
    send_pkt(3, -1, -1, -1, -1, -1);
    quiet(4);

    // Reset in the middle of an ordered set.
    os_req = 1;
    quiet(6);
    rst = 1;
    step_cycle();
    quiet(10);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) gen = ~gen;
      if (!skp_enable && $urandom_range(0, 29) == 0) skp_enable = 1;
      skp_rst = ($urandom_range(0, 49) == 0);
      if (!os_req && $urandom_range(0, 59) == 0) os_req = 1;
      dl_valid = ($urandom_range(0, 3) != 0);
      dl_eop = dl_valid && ($urandom_range(0, 5) == 0);
      phy_ready = ($urandom_range(0, 9) != 0);
      step_cycle();
    end
    quiet(2);

    @(negedge clk);
    #1;
    check("sb_drain", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
